// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32 pipeline: stall/flush/bubble/freeze controls and EX forwarding selects.
// Ports: register ids/enables/load flags from ID, EX, MEM and WB; branch pulse and target; mem_busy.
// Outputs: IF/ID stall (data_hazard) and clear (control_hazard), idex_flush, pipe_freeze, PC redirect, fwd_a/fwd_b, perf counters.
// All control outputs are combinational. Only the pending redirect, the state and the counters are registered.
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic             ID_re1,
    input  logic             ID_re2,
    input  logic [4:0]       EX_rs1,
    input  logic [4:0]       EX_rs2,
    input  logic [4:0]       EX_rd,
    input  logic             EX_we,
    input  logic             EX_is_load,
    input  logic [4:0]       MEM_rd,
    input  logic             MEM_we,
    input  logic             MEM_is_load,
    input  logic [4:0]       WB_rd,
    input  logic             WB_we,
    input  logic             br_pulse,
    input  logic [31:0]      br_target,
    input  logic             mem_busy,
    output logic             data_hazard,
    output logic             control_hazard,
    output logic             idex_flush,
    output logic             pipe_freeze,
    output logic             pc_redirect,
    output logic [31:0]      redirect_pc,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic {RUN, WAIT} state_t;

    state_t           state_q, state_d;
    logic             pend_q, pend_d;
    logic [31:0]      pend_pc_q, pend_pc_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    logic load_use;

    // A load in MEM has no result yet on the EX/MEM path, so it only
    // becomes forwardable once it reaches WB.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (MEM_we && !MEM_is_load && (MEM_rd != 5'd0) && (MEM_rd == rs))
            return 2'b01;
        else if (WB_we && (WB_rd != 5'd0) && (WB_rd == rs))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    assign load_use = EX_is_load && EX_we && (EX_rd != 5'd0) &&
                      ((ID_re1 && (ID_rs1 == EX_rd)) || (ID_re2 && (ID_rs2 == EX_rd)));

    // Outputs: freeze beats redirect beats load-use; reset forces everything low.
    always_comb begin
        data_hazard    = 1'b0;
        control_hazard = 1'b0;
        idex_flush     = 1'b0;
        pipe_freeze    = 1'b0;
        pc_redirect    = 1'b0;
        redirect_pc    = 32'd0;
        fwd_a          = 2'b00;
        fwd_b          = 2'b00;
        if (!rst) begin
            fwd_a       = fwd_sel(EX_rs1);
            fwd_b       = fwd_sel(EX_rs2);
            redirect_pc = br_pulse ? br_target : pend_pc_q;
            if (mem_busy) begin
                pipe_freeze = 1'b1;
                data_hazard = 1'b1;
            end else if (br_pulse || pend_q) begin
                // Any load-use in ID is moot: that instruction is being flushed.
                pc_redirect    = 1'b1;
                control_hazard = 1'b1;
                idex_flush     = 1'b1;
            end else if (load_use) begin
                data_hazard = 1'b1;
                idex_flush  = 1'b1;
            end
        end
    end

    // Next state: pending redirect capture and saturating counters.
    always_comb begin
        state_d        = state_q;
        pend_d         = pend_q;
        pend_pc_d      = pend_pc_q;
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;

        case (state_q)
            RUN:     if (mem_busy)  state_d = WAIT;
            WAIT:    if (!mem_busy) state_d = RUN;
            default: state_d = RUN;
        endcase

        if (mem_busy && br_pulse) begin
            pend_d    = 1'b1;
            pend_pc_d = br_target;
        end else if (pc_redirect) begin
            pend_d = 1'b0;
        end

        if (data_hazard && (stall_cycles_q != {CNT_W{1'b1}}))
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        if (pc_redirect && (flush_count_q != {CNT_W{1'b1}}))
            flush_count_d = flush_count_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= RUN;
            pend_q         <= 1'b0;
            pend_pc_q      <= 32'd0;
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            pend_q         <= pend_d;
            pend_pc_q      <= pend_pc_d;
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ID_rs1, ID_rs2, EX_rs1, EX_rs2, EX_rd, MEM_rd, WB_rd;
    logic        ID_re1, ID_re2, EX_we, EX_is_load, MEM_we, MEM_is_load, WB_we;
    logic        br_pulse, mem_busy;
    logic [31:0] br_target;
    logic        data_hazard, control_hazard, idex_flush, pipe_freeze, pc_redirect;
    logic [31:0] redirect_pc;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cycles, flush_count;

    // Narrow-counter instance on the same inputs, used for saturation.
    logic        n_dh, n_ch, n_fl, n_fz, n_pr;
    logic [31:0] n_rpc;
    logic [1:0]  n_fa, n_fb;
    logic [3:0]  n_stall, n_flush;

    int ncmp  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_re1(ID_re1), .ID_re2(ID_re2),
        .EX_rs1(EX_rs1), .EX_rs2(EX_rs2), .EX_rd(EX_rd), .EX_we(EX_we), .EX_is_load(EX_is_load),
        .MEM_rd(MEM_rd), .MEM_we(MEM_we), .MEM_is_load(MEM_is_load),
        .WB_rd(WB_rd), .WB_we(WB_we),
        .br_pulse(br_pulse), .br_target(br_target), .mem_busy(mem_busy),
        .data_hazard(data_hazard), .control_hazard(control_hazard), .idex_flush(idex_flush),
        .pipe_freeze(pipe_freeze), .pc_redirect(pc_redirect), .redirect_pc(redirect_pc),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    hazard_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_re1(ID_re1), .ID_re2(ID_re2),
        .EX_rs1(EX_rs1), .EX_rs2(EX_rs2), .EX_rd(EX_rd), .EX_we(EX_we), .EX_is_load(EX_is_load),
        .MEM_rd(MEM_rd), .MEM_we(MEM_we), .MEM_is_load(MEM_is_load),
        .WB_rd(WB_rd), .WB_we(WB_we),
        .br_pulse(br_pulse), .br_target(br_target), .mem_busy(mem_busy),
        .data_hazard(n_dh), .control_hazard(n_ch), .idex_flush(n_fl),
        .pipe_freeze(n_fz), .pc_redirect(n_pr), .redirect_pc(n_rpc),
        .fwd_a(n_fa), .fwd_b(n_fb), .stall_cycles(n_stall), .flush_count(n_flush)
    );

    typedef struct packed {
        logic [4:0]  id_rs1, id_rs2;
        logic        id_re1, id_re2;
        logic [4:0]  ex_rs1, ex_rs2, ex_rd;
        logic        ex_we, ex_ld;
        logic [4:0]  mem_rd;
        logic        mem_we, mem_ld;
        logic [4:0]  wb_rd;
        logic        wb_we, br;
        logic [31:0] tgt;
        logic        busy;
        // expected
        logic        dh, ch, fl, fz, pr;
        logic [31:0] rpc;
        logic [1:0]  fa, fb;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        ID_rs1 = 0; ID_rs2 = 0; ID_re1 = 0; ID_re2 = 0;
        EX_rs1 = 0; EX_rs2 = 0; EX_rd = 0; EX_we = 0; EX_is_load = 0;
        MEM_rd = 0; MEM_we = 0; MEM_is_load = 0; WB_rd = 0; WB_we = 0;
        br_pulse = 0; br_target = 0; mem_busy = 0;
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen 3 units later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic apply(input vec_t v);
        ID_rs1 = v.id_rs1; ID_rs2 = v.id_rs2; ID_re1 = v.id_re1; ID_re2 = v.id_re2;
        EX_rs1 = v.ex_rs1; EX_rs2 = v.ex_rs2; EX_rd = v.ex_rd; EX_we = v.ex_we; EX_is_load = v.ex_ld;
        MEM_rd = v.mem_rd; MEM_we = v.mem_we; MEM_is_load = v.mem_ld;
        WB_rd = v.wb_rd; WB_we = v.wb_we;
        br_pulse = v.br; br_target = v.tgt; mem_busy = v.busy;
    endtask

    task automatic load_use_x5();
        idle_inputs();
        ID_rs1 = 5; ID_rs2 = 7; ID_re1 = 1; ID_re2 = 1;
        EX_rd = 5; EX_we = 1; EX_is_load = 1;
    endtask

    initial begin
        //            irs1 irs2 re1 re2 ers1 ers2 erd we ld mrd mwe mld wrd wwe br tgt       busy dh ch fl fz pr rpc       fa     fb
        vecs[0]  = '{5'd0, 5'd0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 32'h0,  0, 0, 0, 0, 0, 0, 32'h0,  2'b00, 2'b00};
        vecs[1]  = '{5'd5, 5'd7, 1, 1, 5'd0, 5'd0, 5'd5, 1, 1, 5'd0, 0, 0, 5'd0, 0, 0, 32'h0,  0, 1, 0, 1, 0, 0, 32'h0,  2'b00, 2'b00};
        vecs[2]  = '{5'd5, 5'd7, 0, 1, 5'd0, 5'd0, 5'd5, 1, 1, 5'd0, 0, 0, 5'd0, 0, 0, 32'h0,  0, 0, 0, 0, 0, 0, 32'h0,  2'b00, 2'b00};
        vecs[3]  = '{5'd1, 5'd9, 1, 1, 5'd0, 5'd0, 5'd9, 1, 1, 5'd0, 0, 0, 5'd0, 0, 0, 32'h0,  0, 1, 0, 1, 0, 0, 32'h0,  2'b00, 2'b00};
        vecs[4]  = '{5'd0, 5'd7, 1, 1, 5'd0, 5'd0, 5'd0, 1, 1, 5'd0, 0, 0, 5'd0, 0, 0, 32'h0,  0, 0, 0, 0, 0, 0, 32'h0,  2'b00, 2'b00};
        vecs[5]  = '{5'd5, 5'd7, 1, 1, 5'd0, 5'd0, 5'd5, 1, 0, 5'd0, 0, 0, 5'd0, 0, 0, 32'h0,  0, 0, 0, 0, 0, 0, 32'h0,  2'b00, 2'b00};
        vecs[6]  = '{5'd5, 5'd7, 1, 1, 5'd0, 5'd0, 5'd5, 0, 1, 5'd0, 0, 0, 5'd0, 0, 0, 32'h0,  0, 0, 0, 0, 0, 0, 32'h0,  2'b00, 2'b00};
        vecs[7]  = '{5'd0, 5'd0, 0, 0, 5'd0, 5'd3, 5'd0, 0, 0, 5'd3, 1, 0, 5'd3, 1, 0, 32'h0,  0, 0, 0, 0, 0, 0, 32'h0,  2'b00, 2'b01};
        vecs[8]  = '{5'd0, 5'd0, 0, 0, 5'd0, 5'd3, 5'd0, 0, 0, 5'd3, 1, 1, 5'd3, 1, 0, 32'h0,  0, 0, 0, 0, 0, 0, 32'h0,  2'b00, 2'b10};
        vecs[9]  = '{5'd0, 5'd0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 5'd0, 1, 0, 32'h0,  0, 0, 0, 0, 0, 0, 32'h0,  2'b00, 2'b00};
        vecs[10] = '{5'd0, 5'd0, 0, 0, 5'd4, 5'd7, 5'd0, 0, 0, 5'd7, 1, 0, 5'd4, 1, 0, 32'h0,  0, 0, 0, 0, 0, 0, 32'h0,  2'b10, 2'b01};
        vecs[11] = '{5'd5, 5'd0, 1, 0, 5'd2, 5'd0, 5'd5, 1, 1, 5'd2, 1, 0, 5'd0, 0, 0, 32'h0,  1, 1, 0, 0, 1, 0, 32'h0,  2'b01, 2'b00};
        vecs[12] = '{5'd5, 5'd0, 1, 0, 5'd0, 5'd0, 5'd5, 1, 1, 5'd0, 0, 0, 5'd0, 0, 1, 32'h40, 0, 0, 1, 1, 0, 1, 32'h40, 2'b00, 2'b00};

        idle_inputs();
        rst = 1'b1;
        #2;
        // Reset state with hazards present on the inputs: everything must read 0.
        load_use_x5();
        br_pulse = 1; br_target = 32'h1234; MEM_rd = 7; MEM_we = 1;
        EX_rs2 = 7;
        #1;
        chk("rst_dh", {31'd0, data_hazard}, 0);
        chk("rst_pr", {31'd0, pc_redirect}, 0);
        chk("rst_ch_fl", {30'd0, control_hazard, idex_flush}, 0);
        chk("rst_rpc", redirect_pc, 0);
        chk("rst_fwd", {28'd0, fwd_a, fwd_b}, 0);
        chk("rst_cnt", {stall_cycles, flush_count}, 0);
        idle_inputs();
        do_reset();

        // Combinational vector table.
        for (int i = 0; i < 13; i++) begin
            apply(vecs[i]);
            #3;
            chk($sformatf("v%0d_dh", i), {31'd0, data_hazard},    {31'd0, vecs[i].dh});
            chk($sformatf("v%0d_ch", i), {31'd0, control_hazard}, {31'd0, vecs[i].ch});
            chk($sformatf("v%0d_fl", i), {31'd0, idex_flush},     {31'd0, vecs[i].fl});
            chk($sformatf("v%0d_fz", i), {31'd0, pipe_freeze},    {31'd0, vecs[i].fz});
            chk($sformatf("v%0d_pr", i), {31'd0, pc_redirect},    {31'd0, vecs[i].pr});
            if (vecs[i].pr)
                chk($sformatf("v%0d_rpc", i), redirect_pc, vecs[i].rpc);
            chk($sformatf("v%0d_fa", i), {30'd0, fwd_a}, {30'd0, vecs[i].fa});
            chk($sformatf("v%0d_fb", i), {30'd0, fwd_b}, {30'd0, vecs[i].fb});
            step();
        end

        // Load-use sequence: one stall cycle, bubble, then WB forwarding.
        idle_inputs();
        do_reset();
        load_use_x5();
        #3;
        chk("lu_c1_dh", {31'd0, data_hazard}, 1);
        chk("lu_c1_fl", {31'd0, idex_flush}, 1);
        step();
        idle_inputs();               // bubble in EX, lw in MEM, add still in ID
        ID_rs1 = 5; ID_re1 = 1; MEM_rd = 5; MEM_we = 1; MEM_is_load = 1;
        #3;
        chk("lu_c2_dh", {31'd0, data_hazard}, 0);
        chk("lu_c2_stall", {16'd0, stall_cycles}, 1);
        step();
        idle_inputs();               // add in EX, lw in WB
        EX_rs1 = 5; EX_rs2 = 7; WB_rd = 5; WB_we = 1;
        #3;
        chk("lu_c3_fwd_a", {30'd0, fwd_a}, 2'b10);
        chk("lu_c3_fwd_b", {30'd0, fwd_b}, 2'b00);
        step();

        // Immediate redirect.
        idle_inputs();
        do_reset();
        br_pulse = 1; br_target = 32'h40;
        #3;
        chk("ir_pr", {31'd0, pc_redirect}, 1);
        chk("ir_rpc", redirect_pc, 32'h40);
        chk("ir_ch_fl", {30'd0, control_hazard, idex_flush}, 2'b11);
        chk("ir_dh", {31'd0, data_hazard}, 0);
        step();
        idle_inputs();
        #3;
        chk("ir_after_pr", {31'd0, pc_redirect}, 0);
        chk("ir_flush_cnt", {16'd0, flush_count}, 1);
        step();

        // Deferred redirect across a 3-cycle freeze.
        idle_inputs();
        do_reset();
        for (int c = 1; c <= 3; c++) begin
            mem_busy = 1; br_pulse = (c == 1); br_target = (c == 1) ? 32'h80 : 32'h0;
            #3;
            chk($sformatf("dr_c%0d_fz", c), {31'd0, pipe_freeze}, 1);
            chk($sformatf("dr_c%0d_pr", c), {31'd0, pc_redirect}, 0);
            chk($sformatf("dr_c%0d_dh", c), {31'd0, data_hazard}, 1);
            step();
        end
        idle_inputs();
        #3;
        chk("dr_c4_pr", {31'd0, pc_redirect}, 1);
        chk("dr_c4_rpc", redirect_pc, 32'h80);
        chk("dr_c4_fz", {31'd0, pipe_freeze}, 0);
        chk("dr_c4_stall", {16'd0, stall_cycles}, 3);
        step();
        #3;
        chk("dr_c5_pr", {31'd0, pc_redirect}, 0);
        chk("dr_c5_flush_cnt", {16'd0, flush_count}, 1);
        step();

        // Reset in the middle of a freeze drops the pending redirect.
        idle_inputs();
        do_reset();
        mem_busy = 1; br_pulse = 1; br_target = 32'h80;
        step();
        br_pulse = 0; br_target = 0;
        rst = 1;
        #3;
        chk("drr_c2_fz", {31'd0, pipe_freeze}, 0);
        step();
        rst = 0;
        #3;
        chk("drr_c3_fz", {31'd0, pipe_freeze}, 1);
        step();
        mem_busy = 0;
        for (int c = 4; c <= 5; c++) begin
            #3;
            chk($sformatf("drr_c%0d_pr", c), {31'd0, pc_redirect}, 0);
            step();
        end
        chk("drr_flush_cnt", {16'd0, flush_count}, 0);

        // Counter saturation on the 4-bit instance.
        idle_inputs();
        do_reset();
        load_use_x5();
        for (int c = 0; c < 20; c++) step();
        #3;
        chk("sat_n_stall_20", {28'd0, n_stall}, 15);
        chk("sat_w_stall_20", {16'd0, stall_cycles}, 20);
        step();
        step();
        #3;
        chk("sat_n_stall_hold", {28'd0, n_stall}, 15);
        idle_inputs();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
